// File: rtl/cp0.sv
// Coprocessor 0: SR, Cause, EPC and PrID for the multi-cycle MIPS core.
// Samples hardware interrupt lines, raises a one-cycle interrupt request,
// captures the resume PC on entry and clears EXL on eret.
module cp0 #(
  parameter logic [31:0] PRID      = 32'h0000_0061,
  parameter int unsigned INT_LINES = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [4:0]           addr,
  input  logic [31:0]          din,
  output logic [31:0]          dout,
  input  logic [31:0]          pc,
  input  logic [INT_LINES-1:0] hwint,
  input  logic                 eret,
  output logic                 intreq,
  output logic [31:0]          epc
);

  localparam logic [4:0] AddrSr    = 5'd12;
  localparam logic [4:0] AddrCause = 5'd13;
  localparam logic [4:0] AddrEpc   = 5'd14;
  localparam logic [4:0] AddrPrid  = 5'd15;

  // The handler state is SR.EXL itself; StHandler reads back as EXL=1.
  typedef enum logic {StNormal, StHandler} state_e;

  state_e                 state_q, state_d;
  logic [INT_LINES-1:0]   im_q, im_d;
  logic                   ie_q, ie_d;
  logic [INT_LINES-1:0]   ip_q, ip_d;
  logic [31:0]            epc_q, epc_d;
  logic                   exl;

  // The low two PC bits are always discarded when forming EPC.
  logic unused_pc_bits;
  assign unused_pc_bits = ^pc[1:0];

  assign exl = (state_q == StHandler);

  // Interrupt request: pending, unmasked, globally enabled and not in a handler.
  always_comb begin
    intreq = (|(ip_q & im_q)) & ie_q & ~exl;
  end

  // Next-state: entry beats mtc0 entirely; eret beats mtc0 only for EXL.
  always_comb begin
    state_d = state_q;
    im_d    = im_q;
    ie_d    = ie_q;
    ip_d    = hwint;
    epc_d   = epc_q;
    if (intreq) begin
      state_d = StHandler;
      epc_d   = pc & 32'hFFFF_FFFC;
    end else begin
      if (we) begin
        case (addr)
          AddrSr: begin
            im_d    = din[15:10];
            ie_d    = din[0];
            state_d = din[1] ? StHandler : StNormal;
          end
          AddrEpc: epc_d = din & 32'hFFFF_FFFC;
          default: ;
        endcase
      end
      if (eret) begin
        state_d = StNormal;
      end
    end
  end

  // State registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StNormal;
      im_q    <= '0;
      ie_q    <= 1'b0;
      ip_q    <= '0;
      epc_q   <= '0;
    end else begin
      state_q <= state_d;
      im_q    <= im_d;
      ie_q    <= ie_d;
      ip_q    <= ip_d;
      epc_q   <= epc_d;
    end
  end

  // mfc0 read mux; always the registered values, no write bypass.
  always_comb begin
    dout = 32'h0;
    unique case (addr)
      AddrSr:    dout = {16'h0, im_q, 8'h0, exl, ie_q};
      AddrCause: dout = {16'h0, ip_q, 10'h0};
      AddrEpc:   dout = epc_q;
      AddrPrid:  dout = PRID;
      default:   dout = 32'h0;
    endcase
  end

  assign epc = epc_q;

endmodule

// File: tb/tb_cp0.sv
// Directed self-checking bench for cp0.
module tb_cp0;

  logic        clk;
  logic        reset;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] din;
  logic [31:0] dout;
  logic [31:0] pc;
  logic [5:0]  hwint;
  logic        eret;
  logic        intreq;
  logic [31:0] epc;

  int n_vec;
  int n_bad;

  cp0 #(
    .PRID      (32'h0000_0061),
    .INT_LINES (6)
  ) u_dut (
    .clk    (clk),
    .reset  (reset),
    .we     (we),
    .addr   (addr),
    .din    (din),
    .dout   (dout),
    .pc     (pc),
    .hwint  (hwint),
    .eret   (eret),
    .intreq (intreq),
    .epc    (epc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point for the whole bench.
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a, input string tag, input logic [31:0] exp);
    addr = a;
    #1;
    check_val(tag, dout, exp);
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we   = 1'b1;
    addr = a;
    din  = d;
    tick();
    we   = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_vec = 0;
    n_bad = 0;
    reset = 1'b1;
    we    = 1'b0;
    addr  = 5'd0;
    din   = 32'h0;
    pc    = 32'h0;
    hwint = 6'b0;
    eret  = 1'b0;
    #12;
    reset = 1'b0;
    tick();

    // Reset state
    check_val("rst_epc", epc, 32'h0);
    check_val("rst_intreq", {31'h0, intreq}, 32'h0);
    rd(5'd12, "rst_sr", 32'h0);

    // Entry
    mtc0(5'd12, 32'h0000_0401);
    rd(5'd12, "sr_wr", 32'h0000_0401);
    pc    = 32'h3008;
    hwint = 6'b000001;
    #1;
    check_val("entry_n", {31'h0, intreq}, 32'h0);
    tick();
    check_val("entry_n1", {31'h0, intreq}, 32'h1);
    rd(5'd13, "cause_ip", 32'h0000_0400);
    tick();
    check_val("entry_n2_req", {31'h0, intreq}, 32'h0);
    check_val("entry_epc", epc, 32'h3008);
    rd(5'd12, "entry_sr", 32'h0000_0403);
    tick();
    check_val("handler_req", {31'h0, intreq}, 32'h0);

    // eret with hwint still high re-requests
    eret = 1'b1;
    tick();
    eret = 1'b0;
    rd(5'd12, "eret_sr", 32'h0000_0401);
    check_val("eret_rereq", {31'h0, intreq}, 32'h1);
    pc = 32'h3010;
    tick();
    check_val("reentry_epc", epc, 32'h3010);
    hwint = 6'b0;
    tick();
    eret = 1'b1;
    tick();
    eret = 1'b0;
    #1;
    check_val("eret_quiet", {31'h0, intreq}, 32'h0);

    // Masking
    hwint = 6'b000010;
    tick();
    check_val("masked", {31'h0, intreq}, 32'h0);
    mtc0(5'd12, 32'h0000_0C01);
    check_val("unmask_req", {31'h0, intreq}, 32'h1);

    // Collision: entry drops the EPC write
    pc = 32'h3020;
    mtc0(5'd14, 32'h0000_4000);
    check_val("collide_epc", epc, 32'h3020);
    rd(5'd12, "collide_sr", 32'h0000_0C03);

    // Reset mid-handler
    mtc0(5'd14, 32'h0000_3010);
    check_val("epc_wr", epc, 32'h3010);
    #2;
    reset = 1'b1;
    #1;
    check_val("midrst_epc", epc, 32'h0);
    check_val("midrst_req", {31'h0, intreq}, 32'h0);
    rd(5'd12, "midrst_sr", 32'h0);
    reset = 1'b0;
    hwint = 6'b0;
    tick();

    // Register map
    we   = 1'b1;
    addr = 5'd14;
    din  = 32'h0000_3007;
    #1;
    check_val("rdw_old", dout, 32'h0);
    tick();
    we = 1'b0;
    rd(5'd14, "epc_align", 32'h0000_3004);
    hwint = 6'b100000;
    tick();
    mtc0(5'd13, 32'hFFFF_FFFF);
    rd(5'd13, "cause_ro", 32'h0000_8000);
    rd(5'd15, "prid", 32'h0000_0061);
    rd(5'd7, "unmapped", 32'h0);
    mtc0(5'd12, 32'hFFFF_FFFF);
    rd(5'd12, "sr_mask", 32'h0000_FC03);
    check_val("exl_blocks", {31'h0, intreq}, 32'h0);
    mtc0(5'd12, 32'h0000_FC01);
    check_val("exl_clear_req", {31'h0, intreq}, 32'h1);
    tick();

    // eret coinciding with SR write forces EXL low
    eret = 1'b1;
    mtc0(5'd12, 32'h0000_0403);
    eret = 1'b0;
    rd(5'd12, "eret_sr_wr", 32'h0000_0401);
    check_val("eret_sr_req", {31'h0, intreq}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
